// File: rtl/alu_result_checker.sv
// alu_result_checker: self-checking sink for the 32-bit ALU datapath IPs.
// Accepts {op, A, B, res} samples, recomputes the golden result, counts
// passes/failures (saturating) and captures the first mismatch for debug.
// Optional build macro: CHK_STOP_ON_ERR_EN -- a mismatch parks the FSM in
// STOP (outputs frozen, in_ready low) until clear or rst_n.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is high only in IDLE with clear=0 and
// rst_n=1; the source holds its sample stable until that edge.
module alu_result_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] res,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [2:0]       err_op,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH-1:0] err_res,
    output logic [WIDTH-1:0] err_exp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_STOP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [2:0]       err_op_q, err_op_d;
    logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d;
    logic [WIDTH-1:0] err_res_q, err_res_d, err_exp_q, err_exp_d;

    logic [WIDTH-1:0] golden;
    logic             reserved;
    logic             match;
    logic             hs;

    assign in_ready = rst_n & ~clear & (state_q == S_IDLE);
    assign hs       = in_valid & in_ready;

    // Golden result from the registered sample; op 101 is flagged reserved.
    always_comb begin
        golden   = '0;
        reserved = 1'b0;
        case (op_q)
            3'b000:  golden = a_q & b_q;
            3'b001:  golden = a_q | b_q;
            3'b010:  golden = a_q + b_q;
            3'b011:  golden = a_q ^ b_q;
            3'b100:  golden = ~(a_q | b_q);
            3'b110:  golden = a_q - b_q;
            3'b111:  golden[0] = ($signed(a_q) < $signed(b_q));
            default: reserved = 1'b1;
        endcase
    end

    assign match = (golden == res_q);

    // Next-state, sample capture, counter and first-error capture logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_flag_d = err_flag_q;
        err_op_d   = err_op_q;
        err_a_d    = err_a_q;
        err_b_d    = err_b_q;
        err_res_d  = err_res_q;
        err_exp_d  = err_exp_q;
        if (clear) begin
            // Clear wins over everything, including a sample in CHECK.
            state_d    = S_IDLE;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_flag_d = 1'b0;
            err_op_d   = '0;
            err_a_d    = '0;
            err_b_d    = '0;
            err_res_d  = '0;
            err_exp_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs) begin
                        op_d    = op;
                        a_d     = A;
                        b_d     = B;
                        res_d   = res;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (!reserved) begin
                        if (match) begin
                            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_ONE;
                        end else begin
                            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_ONE;
                            err_flag_d = 1'b1;
                            if (!err_flag_q) begin
                                err_op_d  = op_q;
                                err_a_d   = a_q;
                                err_b_d   = b_q;
                                err_res_d = res_q;
                                err_exp_d = golden;
                            end
`ifdef CHK_STOP_ON_ERR_EN
                            state_d = S_STOP;
`endif
                        end
                    end
                end
                S_STOP:  state_d = S_STOP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; async reset discards any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_flag_q <= 1'b0;
            err_op_q   <= '0;
            err_a_q    <= '0;
            err_b_q    <= '0;
            err_res_q  <= '0;
            err_exp_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_flag_q <= err_flag_d;
            err_op_q   <= err_op_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            err_res_q  <= err_res_d;
            err_exp_q  <= err_exp_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign err_flag = err_flag_q;
    assign err_op   = err_op_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign err_res  = err_res_q;
    assign err_exp  = err_exp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker, built with CNT_W=4 so saturation
// is reachable in a few samples. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_alu_result_checker;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready;
  logic [2:0]  op;
  logic [31:0] a, b, res;
  logic [3:0]  pass_cnt, fail_cnt;
  logic        err_flag;
  logic [2:0]  err_op;
  logic [31:0] err_a, err_b, err_res, err_exp;

  int n_checks = 0;
  int n_pass = 0;

  alu_result_checker #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(a), .B(b), .res(res),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag), .err_op(err_op),
    .err_a(err_a), .err_b(err_b), .err_res(err_res), .err_exp(err_exp)
  );

  // clock
  always #5 clk = ~clk;

  // Offers one sample, waits (bounded) for the handshake, then waits for the
  // update edge; returns at the falling edge where results are visible.
  task automatic send(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vr);
    int n;
    n = 0;
    @(negedge clk);
    op = o; a = va; b = vb; res = vr; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 20) $display("FAIL handshake_timeout: in_ready=%0b, required 1 within 20 cycles", in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; res = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_checks++; if (pass_cnt !== 4'h0) $display("FAIL rst_pass_cnt: got %h want 0", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 4'h0) $display("FAIL rst_fail_cnt: got %h want 0", fail_cnt); else n_pass++;
    n_checks++; if (err_flag !== 1'b0) $display("FAIL rst_err_flag: got %0b want 0", err_flag); else n_pass++;
    n_checks++;
    if ({err_op, err_a, err_b, err_res, err_exp} !== '0)
      $display("FAIL rst_err_fields: got %h %h %h %h %h want all 0", err_op, err_a, err_b, err_res, err_exp);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_and_pass();
    send(3'b000, 32'h0000F0AF, 32'h0000052B, 32'h0000002B);
    n_checks++; if (pass_cnt !== 4'h1) $display("FAIL and_pass_cnt: got %h want 1", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 4'h0) $display("FAIL and_fail_cnt: got %h want 0", fail_cnt); else n_pass++;
    n_checks++; if (err_flag !== 1'b0) $display("FAIL and_err_flag: got %0b want 0", err_flag); else n_pass++;
  endtask

  task automatic test_and_fail();
    send(3'b000, 32'h0000F0AF, 32'h0000052B, 32'h0000002A);
    n_checks++; if (fail_cnt !== 4'h1) $display("FAIL andf_fail_cnt: got %h want 1", fail_cnt); else n_pass++;
    n_checks++; if (pass_cnt !== 4'h1) $display("FAIL andf_pass_cnt: got %h want 1", pass_cnt); else n_pass++;
    n_checks++; if (err_flag !== 1'b1) $display("FAIL andf_err_flag: got %0b want 1", err_flag); else n_pass++;
    n_checks++; if (err_exp !== 32'h0000002B) $display("FAIL andf_err_exp: got %h want 0000002b", err_exp); else n_pass++;
    n_checks++; if (err_res !== 32'h0000002A) $display("FAIL andf_err_res: got %h want 0000002a", err_res); else n_pass++;
    n_checks++; if (err_a !== 32'h0000F0AF) $display("FAIL andf_err_a: got %h want 0000f0af", err_a); else n_pass++;
    n_checks++; if (err_b !== 32'h0000052B) $display("FAIL andf_err_b: got %h want 0000052b", err_b); else n_pass++;
    n_checks++; if (err_op !== 3'b000) $display("FAIL andf_err_op: got %b want 000", err_op); else n_pass++;
    // second bad sample: OR 1|2 = 3, reported 0
    send(3'b001, 32'h00000001, 32'h00000002, 32'h00000000);
    n_checks++; if (fail_cnt !== 4'h2) $display("FAIL second_fail_cnt: got %h want 2", fail_cnt); else n_pass++;
    n_checks++; if (err_op !== 3'b000) $display("FAIL second_err_op: got %b want 000", err_op); else n_pass++;
    n_checks++; if (err_res !== 32'h0000002A) $display("FAIL second_err_res: got %h want 0000002a", err_res); else n_pass++;
    n_checks++; if (err_exp !== 32'h0000002B) $display("FAIL second_err_exp: got %h want 0000002b", err_exp); else n_pass++;
  endtask

  task automatic test_arith();
    logic [2:0]  ops  [6] = '{3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b111};
    logic [31:0] va   [6] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0F0F0000, 32'h00000001};
    logic [31:0] vb   [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'hFFFF0000, 32'h00F00F00, 32'hFFFFFFFF};
    logic [31:0] vr   [6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h5A5AA5A5, 32'hF000F0FF, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      send(ops[i], va[i], vb[i], vr[i]);
      n_checks++;
      if (pass_cnt !== 4'(2 + i) || fail_cnt !== 4'h2)
        $display("FAIL arith_%0d: got pass=%h fail=%h want pass=%h fail=2", i, pass_cnt, fail_cnt, 4'(2 + i));
      else n_pass++;
    end
  endtask

  task automatic test_reserved();
    send(3'b101, 32'h12345678, 32'h00000000, 32'hDEADBEEF);
    n_checks++;
    if (pass_cnt !== 4'h7 || fail_cnt !== 4'h2)
      $display("FAIL reserved_cnt: got pass=%h fail=%h want pass=7 fail=2", pass_cnt, fail_cnt);
    else n_pass++;
    n_checks++; if (err_res !== 32'h0000002A) $display("FAIL reserved_err_res: got %h want 0000002a", err_res); else n_pass++;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL clear_in_ready: got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    clear = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    n_checks++;
    if (pass_cnt !== 4'h0 || fail_cnt !== 4'h0 || err_flag !== 1'b0 || err_res !== 32'h0)
      $display("FAIL clear_outputs: got pass=%h fail=%h flag=%0b err_res=%h want 0", pass_cnt, fail_cnt, err_flag, err_res);
    else n_pass++;
    op = 3'b010; a = 32'h00000010; b = 32'h00000020; res = 32'h00000030; in_valid = 1'b1;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (in_ready !== ((k % 2) == 0))
        $display("FAIL b2b_in_ready_%0d: got %0b want %0b", k, in_ready, (k % 2) == 0);
      else n_pass++;
      if (k == 30) begin
        n_checks++;
        if (pass_cnt !== 4'hF) $display("FAIL b2b_reach_max: got %h want f", pass_cnt); else n_pass++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (pass_cnt !== 4'hF) $display("FAIL saturate_pass_cnt: got %h want f", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 4'h0) $display("FAIL saturate_fail_cnt: got %h want 0", fail_cnt); else n_pass++;
  endtask

  // Mismatching sample is in CHECK when clear arrives; it must be dropped.
  task automatic test_clear_in_check();
    @(negedge clk);
    op = 3'b000; a = 32'hFFFFFFFF; b = 32'h0000FFFF; res = 32'h00000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_checks++;
    if (pass_cnt !== 4'h0 || fail_cnt !== 4'h0 || err_flag !== 1'b0 || err_exp !== 32'h0)
      $display("FAIL clear_in_check: got pass=%h fail=%h flag=%0b err_exp=%h want 0", pass_cnt, fail_cnt, err_flag, err_exp);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL clear_idle_next: got %0b want 1", in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (fail_cnt !== 4'h0) $display("FAIL clear_dropped: got %h want 0", fail_cnt); else n_pass++;
  endtask

  task automatic test_reset_in_check();
    send(3'b001, 32'h00000100, 32'h00000001, 32'h00000101);
    n_checks++; if (pass_cnt !== 4'h1) $display("FAIL pre_reset_pass: got %h want 1", pass_cnt); else n_pass++;
    @(negedge clk);
    op = 3'b010; a = 32'h1; b = 32'h1; res = 32'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rstcheck_in_ready: got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pass_cnt !== 4'h0 || fail_cnt !== 4'h0 || err_flag !== 1'b0)
      $display("FAIL rstcheck_cnt: got pass=%h fail=%h flag=%0b want 0", pass_cnt, fail_cnt, err_flag);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstcheck_idle: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_stop_on_err();
    send(3'b011, 32'h0000000F, 32'h000000F0, 32'h00000000);
    n_checks++; if (fail_cnt !== 4'h1) $display("FAIL stop_fail_cnt: got %h want 1", fail_cnt); else n_pass++;
`ifdef CHK_STOP_ON_ERR_EN
    op = 3'b010; a = 32'h2; b = 32'h2; res = 32'h4; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== 1'b0 || pass_cnt !== 4'h0 || fail_cnt !== 4'h1)
        $display("FAIL stop_frozen_%0d: got rdy=%0b pass=%h fail=%h want rdy=0 pass=0 fail=1", k, in_ready, pass_cnt, fail_cnt);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    pulse_clear();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stop_release: got %0b want 1", in_ready); else n_pass++;
    n_checks++; if (fail_cnt !== 4'h0) $display("FAIL stop_release_cnt: got %h want 0", fail_cnt); else n_pass++;
`else
    n_checks++; if (in_ready !== 1'b1) $display("FAIL continue_in_ready: got %0b want 1", in_ready); else n_pass++;
    send(3'b010, 32'h2, 32'h2, 32'h4);
    n_checks++;
    if (pass_cnt !== 4'h1 || fail_cnt !== 4'h1)
      $display("FAIL continue_cnt: got pass=%h fail=%h want pass=1 fail=1", pass_cnt, fail_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_and_fail();
    test_arith();
    test_reserved();
    test_back_to_back();
    test_clear_in_check();
    test_reset_in_check();
    test_stop_on_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion before 200000");
    $fatal(1);
  end
endmodule
